// File: rtl/ws_pe_pkg.sv
// ----------------------------------------------------------------------------
// ws_pe_pkg
// Shared constants and arithmetic helpers for the weight-stationary PE.
//   MULT_STAGES_MAX : largest supported number of extra multiplier stages
//   ADD_W           : working width of the generic add/saturate helper
//   add_sat()       : signed add of two sign-extended operands, optionally
//                     clamped to a signed field of 'width' bits
// ----------------------------------------------------------------------------
package ws_pe_pkg;

    localparam int MULT_STAGES_MAX = 1;
    localparam int ADD_W           = 64;

    typedef struct packed {
        logic             sat;
        logic [ADD_W-1:0] sum;
    } add_res_t;

    // Operands arrive sign-extended to ADD_W. The true sum is formed one bit
    // wider so it can never overflow here. Without saturation the caller keeps
    // the low 'width' bits, which is exactly modulo-2^width wrap. 'width' must
    // be at most ADD_W-1.
    function automatic add_res_t add_sat(input logic signed [ADD_W-1:0] x,
                                         input logic signed [ADD_W-1:0] y,
                                         input int                      width,
                                         input logic                    sat_en);
        logic signed [ADD_W:0] full;
        logic signed [ADD_W:0] max_v;
        logic signed [ADD_W:0] min_v;
        add_res_t              r;
        full  = {x[ADD_W-1], x} + {y[ADD_W-1], y};
        max_v = 65'sd1;
        max_v = (max_v <<< (width - 1)) - 65'sd1;
        min_v = -max_v - 65'sd1;
        r.sat = 1'b0;
        r.sum = full[ADD_W-1:0];
        if (sat_en) begin
            if (full > max_v) begin
                r.sat = 1'b1;
                r.sum = max_v[ADD_W-1:0];
            end else if (full < min_v) begin
                r.sat = 1'b1;
                r.sum = min_v[ADD_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ws_pe_mk2_if.sv
// ----------------------------------------------------------------------------
// ws_pe_mk2_if
// Bundles every non-clock/reset signal of one weight-stationary PE.
//   master : the side driving the PE (enable, weight chain in, activation in,
//            partial sum in, sat_clr) and observing its outputs
//   slave  : the PE itself
// ----------------------------------------------------------------------------
interface ws_pe_mk2_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
);
    logic                         enable;
    logic signed [DATA_WIDTH-1:0] b_in;
    logic                         b_valid_in;
    logic                         b_capture;
    logic                         b_swap;
    logic signed [DATA_WIDTH-1:0] b_out;
    logic                         b_valid_out;
    logic signed [DATA_WIDTH-1:0] a_in;
    logic                         a_valid_in;
    logic signed [DATA_WIDTH-1:0] a_out;
    logic                         a_valid_out;
    logic signed [ACC_WIDTH-1:0]  c_in;
    logic signed [ACC_WIDTH-1:0]  c_out;
    logic                         c_valid_out;
    logic                         sat_flag;
    logic                         sat_clr;

    modport master (
        output enable, b_in, b_valid_in, b_capture, b_swap,
               a_in, a_valid_in, c_in, sat_clr,
        input  b_out, b_valid_out, a_out, a_valid_out,
               c_out, c_valid_out, sat_flag
    );

    modport slave (
        input  enable, b_in, b_valid_in, b_capture, b_swap,
               a_in, a_valid_in, c_in, sat_clr,
        output b_out, b_valid_out, a_out, a_valid_out,
               c_out, c_valid_out, sat_flag
    );
endinterface

// File: rtl/ws_pe_mac.sv
// ----------------------------------------------------------------------------
// ws_pe_mac
// Multiply-accumulate datapath of the PE: full-precision signed product,
// optional registered product stage, then add (wrap or saturate).
// Config macro: WS_PE_SAT_EN -- when defined the add saturates and 'sat'
// reports clamping; otherwise the add wraps and 'sat' is always 0.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : advances the optional product stage
//   a, w        : activation and active weight (signed DATA_WIDTH)
//   c           : incoming partial sum (signed ACC_WIDTH)
//   sum, sat    : combinational adder result and its saturation indication
// ----------------------------------------------------------------------------
module ws_pe_mac
    import ws_pe_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int MULT_STAGES = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] w,
    input  logic signed [ACC_WIDTH-1:0]  c,
    output logic signed [ACC_WIDTH-1:0]  sum,
    output logic                         sat
);
    localparam int PW = 2 * DATA_WIDTH;

`ifdef WS_PE_SAT_EN
    localparam logic SAT_EN_C = 1'b1;
`else
    localparam logic SAT_EN_C = 1'b0;
`endif

    logic signed [PW-1:0]        prod_p0;
    logic signed [PW-1:0]        prod_add;
    logic signed [ACC_WIDTH-1:0] c_add;
    add_res_t                    add_res;
    logic                        unused_add_hi;

    assign prod_p0 = PW'(a) * PW'(w);

    // ---- optional product stage: c is delayed with it so both meet at the adder
    generate
        if (MULT_STAGES >= 1) begin : g_prod_stage
            logic signed [PW-1:0]        prod_p1;
            logic signed [ACC_WIDTH-1:0] c_p1;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prod_p1 <= '0;
                    c_p1    <= '0;
                end else if (enable) begin
                    prod_p1 <= prod_p0;
                    c_p1    <= c;
                end
            end
            assign prod_add = prod_p1;
            assign c_add    = c_p1;
        end else begin : g_no_prod_stage
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst_n, enable};
            assign prod_add   = prod_p0;
            assign c_add      = c;
        end
    endgenerate

    // ---- adder stage
    assign add_res       = add_sat(ADD_W'(c_add), ADD_W'(prod_add), ACC_WIDTH, SAT_EN_C);
    assign sum           = add_res.sum[ACC_WIDTH-1:0];
    assign sat           = add_res.sat;
    assign unused_add_hi = ^add_res.sum[ADD_W-1:ACC_WIDTH];

endmodule

// File: rtl/ws_pe_mk2.sv
// ----------------------------------------------------------------------------
// ws_pe_mk2
// Weight-stationary systolic processing element. Holds a double-buffered
// weight (shadow/active), passes weights and activations to neighbours and
// produces c_out = c_in + a_in * active_weight after L = 1 + MULT_STAGES
// enabled cycles.
// Config macro: WS_PE_SAT_EN -- saturating accumulate with sticky sat_flag
// (cleared by sat_clr); undefined: wrapping accumulate, sat_flag tied 0.
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   pe     : ws_pe_mk2_if.slave (weight chain, activation chain, partial
//            sums, enable, sat_flag/sat_clr)
// ----------------------------------------------------------------------------
module ws_pe_mk2
    import ws_pe_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int MULT_STAGES = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    ws_pe_mk2_if.slave     pe
);
    // Out-of-range MULT_STAGES values are clamped to the supported range.
    localparam int MS = (MULT_STAGES > MULT_STAGES_MAX) ? MULT_STAGES_MAX :
                        (MULT_STAGES < 0)               ? 0 : MULT_STAGES;

    logic signed [DATA_WIDTH-1:0] shadow_w;
    logic signed [DATA_WIDTH-1:0] active_w;
    logic                         vld_add;
    logic signed [ACC_WIDTH-1:0]  mac_sum;
    logic                         mac_sat;

    // ---- weight chain: free-running, ignores enable.
    // A swap moves the pre-edge shadow, so capture+swap together never bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe.b_out       <= '0;
            pe.b_valid_out <= 1'b0;
            shadow_w       <= '0;
            active_w       <= '0;
        end else begin
            pe.b_out       <= pe.b_in;
            pe.b_valid_out <= pe.b_valid_in;
            if (pe.b_capture && pe.b_valid_in) shadow_w <= pe.b_in;
            if (pe.b_swap)                     active_w <= shadow_w;
        end
    end

    // ---- activation pass-through stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe.a_out       <= '0;
            pe.a_valid_out <= 1'b0;
        end else if (pe.enable) begin
            pe.a_out       <= pe.a_in;
            pe.a_valid_out <= pe.a_valid_in;
        end
    end

    // ---- valid tracking matching the MAC product stage
    generate
        if (MS >= 1) begin : g_vld_stage
            logic vld_p1;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)          vld_p1 <= 1'b0;
                else if (pe.enable)  vld_p1 <= pe.a_valid_in;
            end
            assign vld_add = vld_p1;
        end else begin : g_no_vld_stage
            assign vld_add = pe.a_valid_in;
        end
    endgenerate

    ws_pe_mac #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH),
        .MULT_STAGES (MS)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (pe.enable),
        .a      (pe.a_in),
        .w      (active_w),
        .c      (pe.c_in),
        .sum    (mac_sum),
        .sat    (mac_sat)
    );

    // ---- output stage: invalid slots leave c_out untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe.c_out       <= '0;
            pe.c_valid_out <= 1'b0;
        end else if (pe.enable) begin
            pe.c_valid_out <= vld_add;
            if (vld_add) pe.c_out <= mac_sum;
        end
    end

`ifdef WS_PE_SAT_EN
    // Sticky flag; a new saturation wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pe.sat_flag <= 1'b0;
        else        pe.sat_flag <= (pe.enable && vld_add && mac_sat) ||
                                   (pe.sat_flag && !pe.sat_clr);
    end
`else
    logic unused_sat;
    assign unused_sat  = ^{pe.sat_clr, mac_sat};
    assign pe.sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_ws_pe_mk2.sv
// ----------------------------------------------------------------------------
// tb_ws_pe_mk2
// Drives identical stimulus into two PEs (MULT_STAGES=0 and 1) and checks
// both against hand-computed results. Honors WS_PE_SAT_EN like the RTL.
// ----------------------------------------------------------------------------
module tb_ws_pe_mk2;
    localparam int DW = 8;
    localparam int AW = 32;
`ifdef WS_PE_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 enable;
    logic signed [DW-1:0] b_in;
    logic                 b_valid_in, b_capture, b_swap;
    logic signed [DW-1:0] a_in;
    logic                 a_valid_in;
    logic signed [AW-1:0] c_in;
    logic                 sat_clr;

    ws_pe_mk2_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) if0 ();
    ws_pe_mk2_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) if1 ();

    assign if0.enable = enable;      assign if1.enable = enable;
    assign if0.b_in = b_in;          assign if1.b_in = b_in;
    assign if0.b_valid_in = b_valid_in; assign if1.b_valid_in = b_valid_in;
    assign if0.b_capture = b_capture;   assign if1.b_capture = b_capture;
    assign if0.b_swap = b_swap;      assign if1.b_swap = b_swap;
    assign if0.a_in = a_in;          assign if1.a_in = a_in;
    assign if0.a_valid_in = a_valid_in; assign if1.a_valid_in = a_valid_in;
    assign if0.c_in = c_in;          assign if1.c_in = c_in;
    assign if0.sat_clr = sat_clr;    assign if1.sat_clr = sat_clr;

    ws_pe_mk2 #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MULT_STAGES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .pe(if0));
    ws_pe_mk2 #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MULT_STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .pe(if1));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Valid/data of both PEs' partial-sum outputs in one call.
    task automatic chk_c(input string tag, input logic v0, input logic [31:0] c0,
                         input logic v1, input logic [31:0] c1);
        check_val({tag, "/v0"}, 32'(if0.c_valid_out), 32'(v0));
        check_val({tag, "/c0"}, if0.c_out, c0);
        check_val({tag, "/v1"}, 32'(if1.c_valid_out), 32'(v1));
        check_val({tag, "/c1"}, if1.c_out, c1);
    endtask

    task automatic chk_zero(input string tag);
        chk_c(tag, 1'b0, 32'd0, 1'b0, 32'd0);
        check_val({tag, "/a0"}, 32'(if0.a_out), 32'd0);
        check_val({tag, "/av0"}, 32'(if0.a_valid_out), 32'd0);
        check_val({tag, "/a1"}, 32'(if1.a_out), 32'd0);
        check_val({tag, "/b0"}, 32'(if0.b_out), 32'd0);
        check_val({tag, "/bv1"}, 32'(if1.b_valid_out), 32'd0);
        check_val({tag, "/s0"}, 32'(if0.sat_flag), 32'd0);
        check_val({tag, "/s1"}, 32'(if1.sat_flag), 32'd0);
    endtask

    task automatic chk_sat(input string tag, input logic s0, input logic s1);
        check_val({tag, "/s0"}, 32'(if0.sat_flag), 32'(s0 & SAT));
        check_val({tag, "/s1"}, 32'(if1.sat_flag), 32'(s1 & SAT));
    endtask

    task automatic drive_a(input logic signed [DW-1:0] a, input logic signed [AW-1:0] c,
                           input logic v);
        a_in = a; c_in = c; a_valid_in = v;
    endtask

    // Capture into shadow, then swap to active on the following cycle.
    task automatic load_w(input logic signed [DW-1:0] w);
        b_in = w; b_valid_in = 1'b1; b_capture = 1'b1; tick();
        b_capture = 1'b0; b_valid_in = 1'b0; b_swap = 1'b1; tick();
        b_swap = 1'b0;
    endtask

    logic [31:0] ovf_exp;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        enable = 1'b0; b_in = '0; b_valid_in = 1'b0; b_capture = 1'b0; b_swap = 1'b0;
        a_in = '0; a_valid_in = 1'b0; c_in = '0; sat_clr = 1'b0;
        ovf_exp = SAT ? 32'h7FFF_FFFF : 32'h8000_3EF1;

        // Reset state
        tick();
        chk_zero("reset");
        rst_n = 1'b1; enable = 1'b1;

        // Basic load and MAC: 10 + 3*5 = 25
        b_in = 8'sd5; b_valid_in = 1'b1; b_capture = 1'b1; tick();
        check_val("b_out", 32'(if0.b_out), 32'd5);
        check_val("b_vout", 32'(if1.b_valid_out), 32'd1);
        b_capture = 1'b0; b_valid_in = 1'b0; b_swap = 1'b1; tick();
        check_val("b_vout_lo", 32'(if0.b_valid_out), 32'd0);
        b_swap = 1'b0;
        drive_a(8'sd3, 32'sd10, 1'b1); tick();
        chk_c("load1", 1'b1, 32'd25, 1'b0, 32'd0);
        check_val("a_out0", 32'(if0.a_out), 32'd3);
        check_val("a_out1", 32'(if1.a_out), 32'd3);
        check_val("a_vout1", 32'(if1.a_valid_out), 32'd1);
        drive_a(8'sd0, 32'sd0, 1'b0); tick();
        chk_c("load2", 1'b0, 32'd25, 1'b1, 32'd25);

        // Swap hazard: active=2, shadow=7, swap coincident with an op
        load_w(8'sd2);
        b_in = 8'sd7; b_valid_in = 1'b1; b_capture = 1'b1; tick();
        b_capture = 1'b0; b_valid_in = 1'b0;
        b_swap = 1'b1; drive_a(8'sd4, 32'sd0, 1'b1); tick();
        chk_c("swap1", 1'b1, 32'd8, 1'b0, 32'd25);
        b_swap = 1'b0; drive_a(8'sd4, 32'sd0, 1'b1); tick();
        chk_c("swap2", 1'b1, 32'd28, 1'b1, 32'd8);
        drive_a(8'sd0, 32'sd0, 1'b0); tick();
        chk_c("swap3", 1'b0, 32'd28, 1'b1, 32'd28);

        // Stall: -3 * 7 = -21, enable low for 3 cycles after launch
        drive_a(-8'sd3, 32'sd0, 1'b1); tick();
        chk_c("stall0", 1'b1, 32'hFFFF_FFEB, 1'b0, 32'd28);
        enable = 1'b0; drive_a(8'sd9, 32'sd100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_c("stall_hold", 1'b1, 32'hFFFF_FFEB, 1'b0, 32'd28);
            check_val("stall_a1", 32'(if1.a_out), 32'hFFFF_FFFD);
        end
        enable = 1'b1; tick();
        chk_c("stall_rel", 1'b0, 32'hFFFF_FFEB, 1'b1, 32'hFFFF_FFEB);

        // Extreme product: -128 * -128 = +16384
        load_w(-8'sd128);
        drive_a(-8'sd128, 32'sd0, 1'b1); tick();
        chk_c("neg1", 1'b1, 32'd16384, 1'b0, 32'hFFFF_FFEB);
        drive_a(8'sd0, 32'sd0, 1'b0); tick();
        chk_c("neg2", 1'b0, 32'd16384, 1'b1, 32'd16384);

        // Overflow: 0x7FFFFFF0 + 127*127
        load_w(8'sd127);
        drive_a(8'sd127, 32'sh7FFF_FFF0, 1'b1); tick();
        chk_c("ovf1", 1'b1, ovf_exp, 1'b0, 32'd16384);
        chk_sat("ovf1", 1'b1, 1'b0);
        drive_a(8'sd1, 32'sd0, 1'b1); tick();
        chk_c("ovf2", 1'b1, 32'd127, 1'b1, ovf_exp);
        chk_sat("ovf2", 1'b1, 1'b1);
        drive_a(8'sd0, 32'sd0, 1'b0); tick();
        chk_sat("sticky", 1'b1, 1'b1);
        // Clear coincident with a new saturation keeps the flag set
        sat_clr = 1'b1; drive_a(8'sd127, 32'sh7FFF_FFF0, 1'b1); tick();
        chk_sat("clr_sat", 1'b1, 1'b0);
        drive_a(8'sd0, 32'sd0, 1'b0); tick();
        chk_sat("clr_sat2", 1'b0, 1'b1);
        tick();
        chk_sat("clr_done", 1'b0, 1'b0);
        sat_clr = 1'b0;

        // Reset mid-stream with both pipelines full
        b_in = 8'sd3; b_valid_in = 1'b1;
        drive_a(8'sd1, 32'sd100, 1'b1); tick(); tick();
        check_val("pre_rst_v1", 32'(if1.c_valid_out), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        drive_a(8'sd0, 32'sd0, 1'b0); b_valid_in = 1'b0; b_in = '0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk_c("post_rst1", 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        chk_c("post_rst2", 1'b0, 32'd0, 1'b0, 32'd0);
        // Weight is 0 after reset, so the result is c_in alone
        drive_a(8'sd5, 32'sd9, 1'b1); tick();
        chk_c("post_rst3", 1'b1, 32'd9, 1'b0, 32'd0);
        drive_a(8'sd0, 32'sd0, 1'b0); tick();
        chk_c("post_rst4", 1'b0, 32'd9, 1'b1, 32'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
